// File: rtl/ts_packet_scheduler_pkg.sv
// rtl/ts_packet_scheduler_pkg.sv - shared constants and state encoding for the TS packet scheduler
//
// Purpose: packet geometry, buffer read latency, inter-packet gap, sync byte,
//          channel count/index width and the scheduler FSM encoding.
// Ports:   none (package).
package ts_packet_scheduler_pkg;

  localparam int CH_NUM     = 4;
  localparam int CH_W       = 2;
  localparam int PKT_LEN    = 188;
  localparam int RD_LAT     = 2;
  localparam int GAP_CYCLES = 4;

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  // Terminal values for the shared 8-bit phase counter.
  localparam logic [7:0] PKT_LAST  = 8'(PKT_LEN - 1);
  localparam logic [7:0] WAIT_LAST = 8'(RD_LAT - 2);
  // GAP runs GAP_CYCLES+1 cycles: its first cycle still presents the last
  // byte from the output register, the remaining GAP_CYCLES are idle.
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_GAP
  } state_e;

endpackage

// File: rtl/ts_packet_scheduler_rr_arbiter4.sv
// rtl/ts_packet_scheduler_rr_arbiter4.sv - four-way round-robin channel picker
//
// Purpose: pick the first eligible channel searching upward from last_grant+1
//          (mod 4); last_grant itself is considered last.
// Ports:   eligible   [3:0] in  channels that may be granted
//          last_grant [1:0] in  most recently granted channel
//          grant      [1:0] out chosen channel (valid when any=1)
//          any              out at least one channel eligible
module rr_arbiter4
  import ts_packet_scheduler_pkg::*;
(
  input  logic [CH_NUM-1:0] eligible,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  always_comb begin
    logic [CH_W-1:0] idx;
    idx   = '0;
    grant = last_grant;
    any   = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = last_grant + CH_W'(k);
      if (eligible[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts_packet_scheduler.sv
// rtl/ts_packet_scheduler.sv - round-robin TS packet scheduler for four tuner channels
//
// Purpose: polls per-channel buffers, requests one 188-byte packet at a time,
//          muxes the returned bytes into one registered TS stream with sync
//          marking, channel tag and sync-byte checking.
// Ports:   SYS_CLK in  clock;  RST in async active-low reset
//          CH_READY[3:0] in buffer holds a full packet; CH_ENABLE[3:0] in scheduling enable
//          CH_REQ[3:0] out one-cycle one-hot packet release; CH_DATA[31:0] in byte i on [8i+7:8i]
//          OUT_READY in downstream accepts a packet (sampled only when arbitrating)
//          TS_DATA[7:0]/TS_VALID/TS_PSYNC/TS_CH[1:0] out output stream
//          SYNC_ERR out byte 0 mismatch pulse; ERR_CNT[15:0] out saturating error count
module ts_packet_scheduler
  import ts_packet_scheduler_pkg::*;
(
  input  logic                SYS_CLK,
  input  logic                RST,
  input  logic [CH_NUM-1:0]   CH_READY,
  input  logic [CH_NUM-1:0]   CH_ENABLE,
  output logic [CH_NUM-1:0]   CH_REQ,
  input  logic [8*CH_NUM-1:0] CH_DATA,
  input  logic                OUT_READY,
  output logic [7:0]          TS_DATA,
  output logic                TS_VALID,
  output logic                TS_PSYNC,
  output logic [CH_W-1:0]     TS_CH,
  output logic                SYNC_ERR,
  output logic [15:0]         ERR_CNT
);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CH_NUM-1:0]   ch_req_q, ch_req_d;
  logic [7:0]          ts_data_q, ts_data_d;
  logic                ts_valid_q, ts_valid_d;
  logic                ts_psync_q, ts_psync_d;
  logic                sync_err_q, sync_err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic [CH_W-1:0]     arb_grant;
  logic                arb_any;
  logic [7:0]          ch_byte;

  rr_arbiter4 u_arb (
    .eligible   (CH_READY & CH_ENABLE),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  assign ch_byte = CH_DATA[{grant_q, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ch_req_d     = '0;
    ts_data_d    = ts_data_q;
    ts_valid_d   = 1'b0;
    ts_psync_d   = 1'b0;
    sync_err_d   = 1'b0;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Request is registered so the pulse lands in the REQ cycle.
        if (OUT_READY && arb_any) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          ch_req_d     = CH_NUM'(1) << arb_grant;
          cnt_d        = '0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STREAM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STREAM: begin
        ts_data_d  = ch_byte;
        ts_valid_d = 1'b1;
        if (cnt_q == 8'd0) begin
          ts_psync_d = 1'b1;
          if (ch_byte != SYNC_BYTE) begin
            sync_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
        end
        if (cnt_q == PKT_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= CH_W'(CH_NUM - 1);
      ch_req_q     <= '0;
      ts_data_q    <= '0;
      ts_valid_q   <= 1'b0;
      ts_psync_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ch_req_q     <= ch_req_d;
      ts_data_q    <= ts_data_d;
      ts_valid_q   <= ts_valid_d;
      ts_psync_q   <= ts_psync_d;
      sync_err_q   <= sync_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign CH_REQ   = ch_req_q;
  assign TS_DATA  = ts_data_q;
  assign TS_VALID = ts_valid_q;
  assign TS_PSYNC = ts_psync_q;
  assign TS_CH    = grant_q;
  assign SYNC_ERR = sync_err_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// tb/tb_ts_packet_scheduler.sv - directed self-checking bench for ts_packet_scheduler
module tb_ts_packet_scheduler;

  logic        SYS_CLK = 1'b0;
  logic        RST;
  logic [3:0]  CH_READY;
  logic [3:0]  CH_ENABLE;
  logic [3:0]  CH_REQ;
  logic [31:0] CH_DATA;
  logic        OUT_READY;
  logic [7:0]  TS_DATA;
  logic        TS_VALID;
  logic        TS_PSYNC;
  logic [1:0]  TS_CH;
  logic        SYNC_ERR;
  logic [15:0] ERR_CNT;

  ts_packet_scheduler dut (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .CH_READY  (CH_READY),
    .CH_ENABLE (CH_ENABLE),
    .CH_REQ    (CH_REQ),
    .CH_DATA   (CH_DATA),
    .OUT_READY (OUT_READY),
    .TS_DATA   (TS_DATA),
    .TS_VALID  (TS_VALID),
    .TS_PSYNC  (TS_PSYNC),
    .TS_CH     (TS_CH),
    .SYNC_ERR  (SYNC_ERR),
    .ERR_CNT   (ERR_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int onehot_bad = 0;
  int req_cyc[$];
  logic [3:0] req_val[$];
  logic [7:0] sync0 [4];
  logic [7:0] ch_data [4];
  int bidx [4];

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  function automatic logic [7:0] byte_of(input int ch, input int k);
    if (k == 0) return sync0[ch];
    return 8'(k + 40 * ch);
  endfunction

  // Buffer model: byte 0 appears RD_LAT cycles after the CH_REQ cycle.
  always @(posedge SYS_CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (CH_REQ[i]) begin
        bidx[i] <= -1;
      end else if (bidx[i] >= -1 && bidx[i] < 187) begin
        bidx[i]    <= bidx[i] + 1;
        ch_data[i] <= byte_of(i, bidx[i] + 1);
      end else begin
        bidx[i]    <= -2;
        ch_data[i] <= 8'hEE;
      end
    end
  end

  assign CH_DATA = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  always @(negedge SYS_CLK) begin
    if (CH_REQ != 4'b0) begin
      req_cyc.push_back(cyc);
      req_val.push_back(CH_REQ);
      if ($countones(CH_REQ) > 1) onehot_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // act: 0 none, 1 drop OUT_READY at byte act_at, 2 drop CH_READY at byte act_at
  task automatic get_packet(input int ch, input logic serr, input logic [15:0] errc,
                            input int act_at, input int act, output int start);
    int t;
    int bad;
    logic [3:0] exp_req;
    t = 0;
    bad = 0;
    start = 0;
    exp_req = 4'b0001 << ch;
    @(negedge SYS_CLK);
    while (!TS_VALID && t < 400) begin
      @(negedge SYS_CLK);
      t++;
    end
    chk("pkt_start_timeout", 32'(TS_VALID), 32'd1);
    if (!TS_VALID) return;
    start = cyc;
    chk("pkt_b0_data", 32'(TS_DATA), 32'(byte_of(ch, 0)));
    chk("pkt_b0_psync", 32'(TS_PSYNC), 32'd1);
    chk("pkt_b0_ch", 32'(TS_CH), 32'(ch));
    chk("pkt_b0_syncerr", 32'(SYNC_ERR), 32'(serr));
    chk("pkt_b0_errcnt", 32'(ERR_CNT), 32'(errc));
    chk("req_seen", 32'(req_cyc.size() > 0), 32'd1);
    if (req_cyc.size() > 0) begin
      chk("req_onehot_value", 32'(req_val[$]), 32'(exp_req));
      chk("req_to_valid_latency", 32'(start - req_cyc[$]), 32'd3);
    end
    for (int k = 0; k < 188; k++) begin
      if (k > 0) @(negedge SYS_CLK);
      if (k == act_at && act == 1) OUT_READY = 1'b0;
      if (k == act_at && act == 2) CH_READY = 4'b0000;
      if (TS_VALID !== 1'b1 || TS_DATA !== byte_of(ch, k) || TS_CH !== 2'(ch) ||
          TS_PSYNC !== (k == 0) || SYNC_ERR !== (k == 0 && serr)) bad++;
    end
    chk("pkt_body_bytes_bad", 32'(bad), 32'd0);
    @(negedge SYS_CLK);
    chk("pkt_len_valid_drops", 32'(TS_VALID), 32'd0);
  endtask

  initial begin
    int s;
    int prev;
    int exp_ch;
    for (int i = 0; i < 4; i++) begin
      sync0[i] = 8'h47;
      bidx[i] = -2;
      ch_data[i] = 8'hEE;
    end
    RST = 1'b0;
    CH_READY = 4'b0000;
    CH_ENABLE = 4'b1111;
    OUT_READY = 1'b0;
    repeat (3) @(negedge SYS_CLK);

    chk("rst_ts_valid", 32'(TS_VALID), 32'd0);
    chk("rst_ts_data", 32'(TS_DATA), 32'd0);
    chk("rst_psync_syncerr", 32'({TS_PSYNC, SYNC_ERR}), 32'd0);
    chk("rst_ts_ch", 32'(TS_CH), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_ch_req", 32'(CH_REQ), 32'd0);
    RST = 1'b1;

    // Single channel
    CH_READY = 4'b0001;
    OUT_READY = 1'b1;
    get_packet(0, 1'b0, 16'd0, -1, 0, s);
    CH_READY = 4'b0000;
    chk("single_req_count", 32'(req_cyc.size()), 32'd1);
    repeat (10) @(negedge SYS_CLK);

    // Fairness from reset: 0,1,2,3,0 at a 196-cycle period
    RST = 1'b0;
    @(negedge SYS_CLK);
    RST = 1'b1;
    CH_READY = 4'b1111;
    prev = 0;
    for (int p = 0; p < 5; p++) begin
      exp_ch = p % 4;
      get_packet(exp_ch, 1'b0, 16'd0, -1, 0, s);
      if (p > 0) chk("fair_spacing", 32'(s - prev), 32'd196);
      prev = s;
    end
    CH_READY = 4'b0000;
    repeat (10) @(negedge SYS_CLK);

    // Masking: only 1 and 3; OUT_READY low in IDLE; OUT_READY dropped mid-packet
    CH_ENABLE = 4'b1010;
    CH_READY = 4'b1111;
    get_packet(1, 1'b0, 16'd0, -1, 0, s);
    get_packet(3, 1'b0, 16'd0, -1, 0, s);
    OUT_READY = 1'b0;
    repeat (10) @(negedge SYS_CLK);
    req_cyc.delete();
    req_val.delete();
    repeat (30) @(negedge SYS_CLK);
    chk("no_req_out_ready_low", 32'(req_cyc.size()), 32'd0);
    OUT_READY = 1'b1;
    get_packet(1, 1'b0, 16'd0, 50, 1, s);
    CH_READY = 4'b0000;
    OUT_READY = 1'b1;
    CH_ENABLE = 4'b1111;
    repeat (10) @(negedge SYS_CLK);

    // Sync error on channel 2, then saturation
    sync0[2] = 8'h00;
    CH_READY = 4'b0100;
    get_packet(2, 1'b1, 16'd1, -1, 0, s);
    CH_READY = 4'b0000;
    chk("err_cnt_after_one", 32'(ERR_CNT), 32'd1);
    repeat (10) @(negedge SYS_CLK);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge SYS_CLK);
    release dut.err_cnt_q;
    @(negedge SYS_CLK);
    chk("err_cnt_preset", 32'(ERR_CNT), 32'hFFFF);
    CH_READY = 4'b0100;
    get_packet(2, 1'b1, 16'hFFFF, -1, 0, s);
    CH_READY = 4'b0000;
    chk("err_cnt_saturated", 32'(ERR_CNT), 32'hFFFF);
    sync0[2] = 8'h47;
    repeat (10) @(negedge SYS_CLK);

    // Reset at byte 100 of a channel-1 packet
    CH_READY = 4'b0010;
    begin
      int t = 0;
      while (!TS_VALID && t < 400) begin
        @(negedge SYS_CLK);
        t++;
      end
    end
    chk("rstmid_start", 32'(TS_VALID), 32'd1);
    CH_READY = 4'b0000;
    repeat (100) @(negedge SYS_CLK);
    chk("rstmid_byte100", 32'(TS_DATA), 32'(byte_of(1, 100)));
    RST = 1'b0;
    #1;
    chk("rstmid_valid", 32'(TS_VALID), 32'd0);
    chk("rstmid_data", 32'(TS_DATA), 32'd0);
    chk("rstmid_ch_errcnt", 32'({TS_CH, ERR_CNT}), 32'd0);
    @(negedge SYS_CLK);
    RST = 1'b1;
    req_cyc.delete();
    req_val.delete();
    CH_READY = 4'b1111;
    get_packet(0, 1'b0, 16'd0, -1, 0, s);
    CH_READY = 4'b0000;
    repeat (10) @(negedge SYS_CLK);

    // Granted channel's CH_READY drops during STREAM
    CH_READY = 4'b0001;
    get_packet(0, 1'b0, 16'd0, 20, 2, s);
    req_cyc.delete();
    req_val.delete();
    repeat (30) @(negedge SYS_CLK);
    chk("no_req_after_ready_drop", 32'(req_cyc.size()), 32'd0);
    CH_READY = 4'b0001;
    get_packet(0, 1'b0, 16'd0, -1, 0, s);
    CH_READY = 4'b0000;
    chk("req_count_reassert", 32'(req_cyc.size()), 32'd1);
    chk("req_never_multi_hot", 32'(onehot_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ts_packet_scheduler.md
# ts_packet_scheduler

Round-robin packet scheduler for the four tuner channels. It polls the per-channel packet buffers for a complete 188-byte TS packet, requests one packet at a time, and muxes the returned bytes into a single SYS_CLK-domain TS stream with sync marking, channel tag and sync-byte checking. It sits between the four per-channel reclock/packet buffers and the downstream output formatter.

## Interface
- PKT_LEN, 188, bytes per TS packet
- RD_LAT, 2, cycles from the CH_REQ pulse cycle to byte 0 on CH_DATA (buffer contract)
- GAP_CYCLES, 4, minimum idle cycles between packets (≥2, lets buffer fill level settle)
- SYNC_BYTE, 8'h47, expected byte 0
- SYS_CLK  in  1  sole clock
- RST  in  1  asynchronous, active-low reset
- CH_READY  in  4  level per channel: buffer holds ≥ PKT_LEN bytes
- CH_ENABLE  in  4  per-channel scheduling enable (quasi-static)
- CH_REQ  out  4  one-hot, one-cycle pulse: release one packet from channel i
- CH_DATA  in  32  channel i byte on [8i+7:8i]
- OUT_READY  in  1  downstream can accept a whole packet; sampled only when arbitrating
- TS_DATA  out  8  output byte
- TS_VALID  out  1  TS_DATA valid
- TS_PSYNC  out  1  high with byte 0 only
- TS_CH  out  2  source channel of current packet, held stable through the packet
- SYNC_ERR  out  1  one-cycle pulse with byte 0 when byte 0 ≠ SYNC_BYTE
- ERR_CNT  out  16  saturating count of SYNC_ERR pulses

## Operation
- States: IDLE, REQ, WAIT, STREAM, GAP.
- IDLE: eligible = CH_READY & CH_ENABLE. If OUT_READY and eligible ≠ 0, choose the first eligible channel searching from last_grant+1 mod 4 upward; latch it as grant and last_grant; → REQ.
- REQ: CH_REQ[grant] = 1 for exactly this cycle; → WAIT.
- WAIT: count RD_LAT−1 cycles; → STREAM.
- STREAM: capture CH_DATA[grant] each cycle for PKT_LEN cycles into the output register; byte counter (8-bit) 0..PKT_LEN−1; after byte PKT_LEN−1 captured → GAP.
- GAP: GAP_CYCLES cycles, outputs invalid; → IDLE.
- CH_READY of the granted channel is ignored from REQ through GAP (its fill level drops while draining).
- CH_ENABLE or OUT_READY deassertion mid-packet does not abort; the packet completes.
- Byte 0 compare against SYNC_BYTE; mismatch → SYNC_ERR with byte 0, ERR_CNT+1 saturating at 16'hFFFF; packet still forwarded unmodified.
- last_grant reset value 3, so channel 0 wins first.

## Timing
- Reset (async, immediate, including mid-packet): state IDLE, CH_REQ=0, TS_DATA=0, TS_VALID=0, TS_PSYNC=0, TS_CH=0, SYNC_ERR=0, ERR_CNT=0, counters 0, last_grant=3.
- Cycle n: IDLE decision. Cycle n+1: CH_REQ pulse. Cycle n+1+RD_LAT: byte 0 on CH_DATA. Cycle n+2+RD_LAT: TS_VALID=1, TS_PSYNC=1, byte 0 on TS_DATA (one registered stage).
- TS_VALID continuous for PKT_LEN cycles; TS_PSYNC, SYNC_ERR only on the first.
- TS_CH updated at the REQ cycle, stable until the next REQ.
- Next arbitration earliest GAP_CYCLES+1 cycles after the last TS_VALID cycle; back-to-back packet period = 1+1+RD_LAT+PKT_LEN+GAP_CYCLES (RD_LAT=2, GAP=4 → 196 cycles worst-case, well within 4-channel TS bandwidth at SYS_CLK).
- Never more than one CH_REQ bit high; never a CH_REQ while not IDLE→REQ.

## Structure
- Shared package: PKT_LEN, SYNC_BYTE, channel count (4), channel index width (2), state encoding.
- One sub-module: rr_arbiter4 (eligible[3:0], last_grant → grant index + any); the rest (FSM, counters, output register, error counter) stays in ts_packet_scheduler.

## Test plan
- Single channel: CH_READY=0001, OUT_READY=1, buffer model returns 0x47,1..187 → one CH_REQ=0001 pulse, TS_VALID 188 cycles starting 4 cycles after decision, TS_PSYNC on 0x47, TS_CH=0, no SYNC_ERR.
- Fairness: CH_READY=1111 held → grant order 0,1,2,3,0; each packet 188 bytes; spacing exactly 196 cycles.
- Masking/backpressure: CH_ENABLE=1010 → only channels 1,3 served; OUT_READY=0 in IDLE → no CH_REQ until it returns to 1; OUT_READY dropped mid-packet → packet completes.
- Sync error: byte 0 = 0x00 on channel 2 → SYNC_ERR pulse with TS_PSYNC, ERR_CNT 0→1, 188 bytes forwarded; force ERR_CNT to 0xFFFF → stays 0xFFFF.
- Reset mid-packet at byte 100 → all outputs 0 same cycle; after release channel 0 granted first, full 188-byte packet.
- CH_READY of granted channel drops to 0 during STREAM → no effect on the packet; no second CH_REQ to it until GAP ends and it re-asserts.
